// File: rtl/wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter.
// Requester indices name the fixed ports: ALU, load unit, mul/div unit.
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam int REQ_ALU    = 0;
   localparam int REQ_LOAD   = 1;
   localparam int REQ_MULDIV = 2;

   typedef logic [REG_ADDR_W-1:0] regAddr_t;
   typedef logic [REG_DATA_W-1:0] regData_t;

   function automatic int ptrWidth(input int nReq);
      return (nReq <= 2) ? 1 : $clog2(nReq);
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus between the requesters/decode stage and the arbiter.
// slave is the arbiter's view, master the environment's view.
interface wb_arbiter_if
   import wb_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
);

   logic [N_REQ-1:0]            req_valid;
   logic [REG_ADDR_W*N_REQ-1:0] req_addr;
   logic [REG_DATA_W*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]            req_ready;
   logic                        regwriteEn;
   regAddr_t                    regwriteaddr;
   regData_t                    regwritedata;
   regAddr_t                    rsaddr;
   regAddr_t                    rtaddr;
   logic                        rs_fwd;
   logic                        rt_fwd;
   regData_t                    fwd_data;

   modport slave (
      input  req_valid, req_addr, req_data, rsaddr, rtaddr,
      output req_ready, regwriteEn, regwriteaddr, regwritedata,
             rs_fwd, rt_fwd, fwd_data
   );

   modport master (
      output req_valid, req_addr, req_data, rsaddr, rtaddr,
      input  req_ready, regwriteEn, regwriteaddr, regwritedata,
             rs_fwd, rt_fwd, fwd_data
   );

endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Rotate-priority encoder: the lowest valid index at or after i_ptr wins.
// Driven with i_ptr = 0 it degenerates to plain fixed priority.
module wb_rr_pick #(
   parameter int N_REQ = 3,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_grant
);

   logic [2*N_REQ-1:0] w_validDbl;
   logic [2*N_REQ-1:0] w_grantDbl;
   logic [N_REQ-1:0]   w_rot;
   logic [N_REQ-1:0]   w_rotGrant;

   // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
   assign w_validDbl = {i_valid, i_valid};
   assign w_rot      = N_REQ'(w_validDbl >> i_ptr);
   assign w_rotGrant = w_rot & (~w_rot + N_REQ'(1));
   assign w_grantDbl = {w_rotGrant, w_rotGrant} << i_ptr;
   assign o_grant    = N_REQ'(w_grantDbl >> N_REQ);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants one requester per cycle and registers the write.
// Define WB_ARB_RR_EN for round-robin; otherwise lowest index has fixed priority.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_arbiter_if.slave bus
);

   localparam int PTR_W = ptrWidth(N_REQ);

   logic [PTR_W-1:0] w_ptr;
   logic [N_REQ-1:0] w_grant;
   logic             w_xfer;
   regAddr_t         w_addr;
   regData_t         w_data;

   logic             r_wen;
   regAddr_t         r_waddr;
   regData_t         r_wdata;

`ifdef WB_ARB_RR_EN
   logic [PTR_W-1:0] r_ptr;
   logic [PTR_W-1:0] w_gntIdx;

   assign w_ptr = r_ptr;

   always_comb begin
      w_gntIdx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_gntIdx = PTR_W'(i);
         end
      end
   end

   // Pointer moves just past the winner, so the winner becomes lowest priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_xfer) begin
         r_ptr <= (w_gntIdx == PTR_W'(N_REQ-1)) ? '0 : w_gntIdx + PTR_W'(1);
      end
   end
`else
   assign w_ptr = '0;
`endif

   wb_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_valid (bus.req_valid),
      .i_ptr   (w_ptr),
      .o_grant (w_grant)
   );

   assign w_xfer = |w_grant;

   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant[i]) begin
            w_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
            w_data = bus.req_data[i*REG_DATA_W +: REG_DATA_W];
         end
      end
   end

   // Writes to r0 are accepted but never enabled, since r0 is hardwired zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wen   <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_wen <= w_xfer && (w_addr != '0);
         if (w_xfer) begin
            r_waddr <= w_addr;
            r_wdata <= w_data;
         end
      end
   end

   assign bus.req_ready    = rst_n ? w_grant : '0;
   assign bus.regwriteEn   = r_wen;
   assign bus.regwriteaddr = r_waddr;
   assign bus.regwritedata = r_wdata;
   assign bus.fwd_data     = r_wdata;
   assign bus.rs_fwd       = r_wen && (bus.rsaddr == r_waddr) && (bus.rsaddr != '0);
   assign bus.rt_fwd       = r_wen && (bus.rtaddr == r_waddr) && (bus.rtaddr != '0);

endmodule
